// File: rtl/pong_input_cond_pkg.sv
// Shared constants for the pong input conditioning stage: paddle command
// bit positions, key indices, default debounce window and the per-paddle
// up/down resolution rule.
package pong_input_cond_pkg;

  // 10 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_CNT_W           = 20;

  localparam int NUM_SW  = 10;
  localparam int NUM_KEY = 3;

  // paddle_ctrl = {p1_up, p1_dn, p2_up, p2_dn}
  localparam int P1_UP = 3;
  localparam int P1_DN = 2;
  localparam int P2_UP = 1;
  localparam int P2_DN = 0;

  // key_db / key_press indices (KEY1 -> 0, KEY2 -> 1, KEY3 -> 2)
  localparam int KEY_PAUSE = 0;
  localparam int KEY_P1_DN = 1;
  localparam int KEY_P1_UP = 2;

  // Returns {up, dn}; conflicting requests cancel to no movement.
  function automatic logic [1:0] resolve_move(input logic up, input logic dn);
    return (up ^ dn) ? {up, dn} : 2'b00;
  endfunction

endpackage

// File: rtl/pong_input_cond_debounce_bit.sv
// One conditioned input bit: 2-flop synchroniser, optional inversion of the
// synchronised level, and a hold-time debouncer. The stable level only
// changes after the synchronised level has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; any return to the stable level
// restarts the window.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit INVERT          = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             w_synced;

  // Inversion happens after the synchroniser so the flops stay plain.
  assign w_synced = r_sync2 ^ INVERT;
  assign o_level  = r_stable;

  // Bring the asynchronous raw input into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level on the last one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (w_synced == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= w_synced;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pong_input_cond.sv
// Input conditioning for the pong core. Debounces the board switches and
// keys, produces key press pulses, detects the start of each frame from
// VGA_VS and presents frame-stable paddle commands plus a pause flag.
// The pause toggle is resolved before the frame load, so a KEY1 press
// landing on a frame tick is honoured by that same tick.
module pong_input_cond
  import pong_input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic [3:1]   KEY,
  input  logic [9:0]   SW,
  input  logic         VGA_VS,
  output logic [9:0]   sw_db,
  output logic [2:0]   key_db,
  output logic [2:0]   key_press,
  output logic         frame_tick,
  output logic [3:0]   paddle_ctrl,
  output logic         paused
);

  logic [NUM_SW-1:0]  w_sw_db;
  logic [NUM_KEY-1:0] w_key_db;
  logic [NUM_KEY-1:0] r_key_db_prev;
  logic [NUM_KEY-1:0] r_key_press;
  logic               r_vs_s1;
  logic               r_vs_s2;
  logic               r_vs_prev;
  logic               r_frame_tick;
  logic               r_paused;
  logic               w_paused_next;
  logic [3:0]         r_paddle;
  logic [3:0]         w_request;

  genvar g;

  // Slide switches: straight level, no inversion.
  generate
    for (g = 0; g < NUM_SW; g++) begin : g_sw
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .INVERT          (1'b0)
      ) u_db (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_raw   (SW[g]),
        .o_level (w_sw_db[g])
      );
    end
  endgenerate

  // Keys are active-low on the board; the debounced level is active-high.
  generate
    for (g = 0; g < NUM_KEY; g++) begin : g_key
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .INVERT          (1'b1)
      ) u_db (
        .i_clk   (CLOCK_50),
        .i_rst_n (RESET_N),
        .i_raw   (KEY[g+1]),
        .o_level (w_key_db[g])
      );
    end
  endgenerate

  // Rising-edge detect on the debounced keys.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_key_db_prev <= '0;
      r_key_press   <= '0;
    end else begin
      r_key_db_prev <= w_key_db;
      r_key_press   <= w_key_db & ~r_key_db_prev;
    end
  end

  // Synchronise VS (idle high) and pulse once on each falling edge.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_vs_s1      <= 1'b1;
      r_vs_s2      <= 1'b1;
      r_vs_prev    <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_s1      <= VGA_VS;
      r_vs_s2      <= r_vs_s1;
      r_vs_prev    <= r_vs_s2;
      r_frame_tick <= r_vs_prev & ~r_vs_s2;
    end
  end

  assign w_paused_next = r_paused ^ r_key_press[KEY_PAUSE];

  assign w_request[P1_UP:P1_DN] = resolve_move(w_key_db[KEY_P1_UP], w_key_db[KEY_P1_DN]);
  assign w_request[P2_UP:P2_DN] = resolve_move(w_sw_db[0], w_sw_db[1]);

  // Pause toggle, then frame-aligned load of the paddle commands.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_paused <= 1'b0;
      r_paddle <= '0;
    end else begin
      r_paused <= w_paused_next;
      if (r_frame_tick) begin
        r_paddle <= w_paused_next ? 4'b0000 : w_request;
      end
    end
  end

  assign sw_db       = w_sw_db;
  assign key_db      = w_key_db;
  assign key_press   = r_key_press;
  assign frame_tick  = r_frame_tick;
  assign paddle_ctrl = r_paddle;
  assign paused      = r_paused;

endmodule

// File: tb/tb_pong_input_cond.sv
// Bench for pong_input_cond with a short debounce window. A reference model
// derived from the input history pushes the expected output vector each
// cycle; a monitor pops and compares on the falling edge. Directed
// sequences add latency and boundary checks on top.
module tb_pong_input_cond;

  localparam int D  = 8;
  localparam int CW = 4;
  localparam int OW = 22;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic [3:1] KEY;
  logic [9:0] SW;
  logic       VGA_VS;
  logic [9:0] sw_db;
  logic [2:0] key_db;
  logic [2:0] key_press;
  logic       frame_tick;
  logic [3:0] paddle_ctrl;
  logic       paused;

  int n_checks = 0;
  int n_errors = 0;

  logic [OW-1:0] exp_q[$];

  typedef struct packed {
    logic [9:0] sw;
    logic [2:0] key;
    logic       vs;
  } smp_t;

  pong_input_cond #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .KEY         (KEY),
    .SW          (SW),
    .VGA_VS      (VGA_VS),
    .sw_db       (sw_db),
    .key_db      (key_db),
    .key_press   (key_press),
    .frame_tick  (frame_tick),
    .paddle_ctrl (paddle_ctrl),
    .paused      (paused)
  );

  // ---------------- clock / reset ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] dut_vec();
    return {sw_db, key_db, key_press, frame_tick, paddle_ctrl, paused};
  endfunction

  function automatic logic [1:0] ref_move(input logic up, input logic dn);
    if (up && !dn) return 2'b10;
    if (dn && !up) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  // ---------------- reference model ----------------
  // History view: the level a debouncer compares at edge t is the input
  // sampled two edges earlier; a frame starts when the VS samples from
  // three and two edges ago read 1 then 0. A bit's debounced level flips
  // after D consecutive edges of disagreement.
  initial begin
    logic [9:0] m_sw;
    logic [2:0] m_key, m_key_prev, m_press;
    logic       m_tick, m_paused;
    logic [3:0] m_paddle;
    int         m_run[13];
    smp_t       m_hist[$];
    smp_t       cur, c2, c3, fill;
    logic [12:0] lvl, stab;
    logic [2:0]  n_press;
    logic        n_paused, n_tick;
    logic [3:0]  n_paddle;
    m_sw = '0; m_key = '0; m_key_prev = '0; m_press = '0;
    m_tick = 1'b0; m_paused = 1'b0; m_paddle = '0;
    forever begin
      @(posedge CLOCK_50);
      if (!RESET_N) begin
        m_sw = '0; m_key = '0; m_key_prev = '0; m_press = '0;
        m_tick = 1'b0; m_paused = 1'b0; m_paddle = '0;
        for (int i = 0; i < 13; i++) m_run[i] = 0;
        m_hist = {};
        fill.sw = '0; fill.key = 3'b111; fill.vs = 1'b1;
        repeat (3) m_hist.push_front(fill);
        exp_q.push_back('0);
      end else begin
        cur.sw = SW; cur.key = ~KEY; cur.vs = VGA_VS;
        m_hist.push_front(cur);
        while (m_hist.size() > 4) void'(m_hist.pop_back());
        c2 = m_hist[2];
        c3 = m_hist[3];
        n_press  = m_key & ~m_key_prev;
        n_paused = m_paused ^ m_press[0];
        n_tick   = c3.vs & ~c2.vs;
        if (m_tick)
          n_paddle = n_paused ? 4'b0000 : {ref_move(m_key[2], m_key[1]), ref_move(m_sw[0], m_sw[1])};
        else
          n_paddle = m_paddle;
        lvl  = {c2.key, c2.sw};
        stab = {m_key, m_sw};
        for (int i = 0; i < 13; i++) begin
          if (lvl[i] == stab[i]) begin
            m_run[i] = 0;
          end else begin
            m_run[i]++;
            if (m_run[i] == D) begin
              stab[i] = lvl[i];
              m_run[i] = 0;
            end
          end
        end
        m_key_prev = m_key;
        {m_key, m_sw} = stab;
        m_press  = n_press;
        m_paused = n_paused;
        m_tick   = n_tick;
        m_paddle = n_paddle;
        exp_q.push_back({m_sw, m_key, m_press, m_tick, m_paddle, m_paused});
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(negedge CLOCK_50);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (!RESET_N) e = '0;
        check("outputs", 32'(dut_vec()), 32'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int vs_cnt;
    int idx;
    int db_at, p_at, n_p;
    logic early;

    RESET_N = 1'b0;
    KEY     = 3'b111;
    SW      = '0;
    VGA_VS  = 1'b1;
    step(1);
    check("reset_state", 32'(dut_vec()), 32'd0);
    step(2);
    RESET_N = 1'b1;

    // Randomised activity on every input.
    vs_cnt = 20;
    for (int c = 0; c < 1500; c++) begin
      step(1);
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, 9);
        SW[idx] = ~SW[idx];
      end
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(1, 3);
        KEY[idx] = ~KEY[idx];
      end
      if (vs_cnt == 0) begin
        VGA_VS = ~VGA_VS;
        vs_cnt = VGA_VS ? $urandom_range(12, 40) : $urandom_range(1, 4);
      end else begin
        vs_cnt--;
      end
    end

    // Asynchronous reset mid-run.
    RESET_N = 1'b0;
    #1;
    check("rst_sw_db", 32'(sw_db), 32'd0);
    check("rst_key_db", 32'(key_db), 32'd0);
    check("rst_key_press", 32'(key_press), 32'd0);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check("rst_paddle", 32'(paddle_ctrl), 32'd0);
    check("rst_paused", 32'(paused), 32'd0);
    KEY = 3'b111; SW = '0; VGA_VS = 1'b1;
    step(3);
    RESET_N = 1'b1;
    step(20);
    check("post_reset_idle", 32'(dut_vec()), 32'd0);

    // Bounce rejection on SW[0].
    early = 1'b0;
    for (int p = 0; p < 14; p++) begin
      SW[0] = (p % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        step(1);
        if (sw_db[0]) early = 1'b1;
      end
    end
    SW[0] = 1'b1;
    db_at = -1;
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (sw_db[0] && db_at < 0) db_at = k;
      if (k < 10 && sw_db[0]) early = 1'b1;
    end
    check("bounce_no_early", 32'(early), 32'd0);
    check("bounce_latency", 32'(db_at), 32'd10);
    SW[0] = 1'b0;
    step(14);

    // Press pulse and pause toggle on KEY1.
    KEY[1] = 1'b0;
    db_at = -1; p_at = -1; n_p = 0;
    for (int k = 1; k <= 50; k++) begin
      step(1);
      if (key_db[0] && db_at < 0) db_at = k;
      if (key_press[0]) begin
        n_p++;
        p_at = k;
      end
    end
    check("key_db_latency", 32'(db_at), 32'd10);
    check("press_cycle", 32'(p_at), 32'd11);
    check("press_count", 32'(n_p), 32'd1);
    check("paused_on", 32'(paused), 32'd1);
    KEY[1] = 1'b1; step(15);
    KEY[1] = 1'b0; step(15);
    KEY[1] = 1'b1; step(15);
    check("paused_off", 32'(paused), 32'd0);

    // Frame alignment with KEY3 (p1_up).
    KEY = 3'b011;
    step(14);
    check("hold_between_ticks", 32'(paddle_ctrl), 32'd0);
    VGA_VS = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      check("frame_align", 32'(paddle_ctrl), (k < 4) ? 32'h0 : 32'h8);
    end
    step(4);
    VGA_VS = 1'b1;
    KEY = 3'b111;
    step(14);

    // Conflicting p2 request, KEY2 (p1_dn).
    SW[1:0] = 2'b11;
    KEY = 3'b101;
    step(14);
    VGA_VS = 1'b0; step(5);
    check("conflict", 32'(paddle_ctrl), 32'h4);
    VGA_VS = 1'b1;
    KEY[1] = 1'b0; step(14);
    KEY[1] = 1'b1; step(14);
    check("paused_conflict", 32'(paused), 32'd1);
    VGA_VS = 1'b0; step(5);
    check("paused_frame", 32'(paddle_ctrl), 32'h0);
    VGA_VS = 1'b1; step(5);

    // Unpause, load p2_up, then a KEY1 press coinciding with frame_tick.
    KEY[1] = 1'b0; step(14);
    KEY[1] = 1'b1; step(14);
    check("unpaused", 32'(paused), 32'd0);
    KEY = 3'b111;
    SW[1:0] = 2'b01;
    step(14);
    VGA_VS = 1'b0; step(5);
    check("p2_up_frame", 32'(paddle_ctrl), 32'h2);
    VGA_VS = 1'b1; step(14);
    KEY[1] = 1'b0;
    step(8);
    VGA_VS = 1'b0;
    step(3);
    check("coincide_press", 32'(key_press[0]), 32'd1);
    check("coincide_tick", 32'(frame_tick), 32'd1);
    step(1);
    check("simul_paused", 32'(paused), 32'd1);
    check("simul_paddle", 32'(paddle_ctrl), 32'h0);
    KEY[1] = 1'b1;
    VGA_VS = 1'b1;
    step(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
